// File: rtl/secuenciador_prueba_mnc_if.sv
// Bus between the self-test sequencer and its user / circuit under test.
// Master drives control and circuit responses; slave is the sequencer.
interface secuenciador_prueba_mnc_if;
  logic       start;
  logic       abort;
  logic       f1;
  logic       f2;
  logic [3:0] abcd;
  logic       busy;
  logic       done;
  logic       pass;
  logic       mismatch;
  logic [4:0] error_count;
  logic [3:0] first_err_idx;
  logic [3:0] cur_idx;

  modport master (
    output start, abort, f1, f2,
    input  abcd, busy, done, pass, mismatch,
    input  error_count, first_err_idx, cur_idx
  );

  modport slave (
    input  start, abort, f1, f2,
    output abcd, busy, done, pass, mismatch,
    output error_count, first_err_idx, cur_idx
  );
endinterface

// File: rtl/secuenciador_prueba_mnc.sv
// Self-test sequencer for the 4-in/2-out gate circuit.
// Sweeps abcd, waits SETTLE cycles, checks {f1,f2} vs GOLDEN.
module secuenciador_prueba_mnc #(
  parameter int          N_CASES     = 16,
  parameter int          SETTLE      = 2,
  parameter logic [31:0] GOLDEN      = 32'hEEEE_76EC,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  secuenciador_prueba_mnc_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(N_CASES - 1);
  localparam logic [3:0] SINI = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] abcd_q, abcd_d;
  logic [3:0] cur_q, cur_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mm_q, mm_d;
  logic [4:0] err_q, err_d;
  logic [3:0] first_q, first_d;

  logic [1:0] exp_w;
  logic       hit;
  logic       last;

  assign exp_w = {GOLDEN[{idx_q, 1'b1}],
                  GOLDEN[{idx_q, 1'b0}]};
  assign hit   = {bus.f1, bus.f2} != exp_w;
  assign last  = (idx_q == LAST) ||
                 (hit && STOP_ON_ERR);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mm_d    = 1'b0;
    err_d   = err_q;
    first_d = first_q;

    if (bus.abort) begin
      // Abort only leaves IDLE untouched; results stay readable.
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        abcd_d  = 4'd0;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d = S_APPLY;
            idx_d   = 4'd0;
            err_d   = 5'd0;
            first_d = 4'd0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_APPLY: begin
          abcd_d  = idx_q;
          cur_d   = idx_q;
          cnt_d   = SINI;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) state_d = S_CHECK;
          else               cnt_d   = cnt_q - 4'd1;
        end
        S_CHECK: begin
          if (hit) begin
            err_d = err_q + 5'd1;
            mm_d  = 1'b1;
            if (err_q == 5'd0) first_d = idx_q;
          end
          if (last) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = !hit && (err_q == 5'd0);
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_APPLY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      abcd_q  <= 4'd0;
      cur_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= 1'b0;
      err_q   <= 5'd0;
      first_q <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign bus.abcd          = abcd_q;
  assign bus.cur_idx       = cur_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.mismatch      = mm_q;
  assign bus.error_count   = err_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_secuenciador_prueba_mnc.sv
// Directed bench for the self-test sequencer.
// Mismatch pulses are scoreboarded against a queue of expected indices.
module tb_secuenciador_prueba_mnc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  secuenciador_prueba_mnc_if m0 ();
  secuenciador_prueba_mnc_if m1 ();

  secuenciador_prueba_mnc dut0 (
    .clk (clk),
    .rst (rst),
    .bus (m0)
  );

  secuenciador_prueba_mnc #(
    .STOP_ON_ERR (1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (m1)
  );

  logic [31:0] gold = 32'hEEEE_76EC;
  logic        fault = 1'b0;

  assign m0.f1 = gold[{m0.abcd, 1'b1}];
  assign m0.f2 = fault ? 1'b0 : gold[{m0.abcd, 1'b0}];
  assign m1.f1 = gold[{m1.abcd, 1'b1}];
  assign m1.f2 = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int mmq[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m0.mismatch === 1'b1) begin
      int e;
      e = (mmq.size() != 0) ? mmq.pop_front() : -1;
      chk("mm_idx", 32'(m0.cur_idx), 32'(e));
    end
  end

  task automatic chk_reset0();
    chk("rst_abcd",  32'(m0.abcd), 0);
    chk("rst_cur",   32'(m0.cur_idx), 0);
    chk("rst_busy",  32'(m0.busy), 0);
    chk("rst_done",  32'(m0.done), 0);
    chk("rst_pass",  32'(m0.pass), 0);
    chk("rst_mm",    32'(m0.mismatch), 0);
    chk("rst_err",   32'(m0.error_count), 0);
    chk("rst_first", 32'(m0.first_err_idx), 0);
  endtask

  task automatic push_fails(input logic f, input int upto);
    for (int i = 0; i <= upto; i++)
      if (f && gold[2*i]) mmq.push_back(i);
  endtask

  task automatic run_sweep(input logic f, input bit poke);
    int n;
    int first;
    n = 0;
    first = 0;
    fault = f;
    for (int i = 0; i < 16; i++) begin
      if (f && gold[2*i]) begin
        if (n == 0) first = i;
        n++;
      end
    end
    push_fails(f, 15);
    @(negedge clk) m0.start = 1'b1;
    @(negedge clk) m0.start = 1'b0;
    chk("sw_busy0", 32'(m0.busy), 1);
    chk("sw_done0", 32'(m0.done), 0);
    chk("sw_err0",  32'(m0.error_count), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sw_abcd", 32'(m0.abcd), 32'(i));
      chk("sw_cur",  32'(m0.cur_idx), 32'(i));
      chk("sw_busy", 32'(m0.busy), 1);
      if (poke && i == 4) begin
        m0.start = 1'b1;
        @(negedge clk) m0.start = 1'b0;
        repeat (2) @(negedge clk);
      end else if (i == 15) begin
        repeat (2) @(negedge clk);
        chk("sw_done63", 32'(m0.done), 0);
        @(negedge clk);
      end else begin
        repeat (3) @(negedge clk);
      end
    end
    chk("sw_done64", 32'(m0.done), 1);
    chk("sw_busyd",  32'(m0.busy), 0);
    chk("sw_pass",   32'(m0.pass), 32'(n == 0));
    chk("sw_err",    32'(m0.error_count), 32'(n));
    chk("sw_first",  32'(m0.first_err_idx), 32'(first));
    chk("sw_hold",   32'(m0.abcd), 15);
    @(negedge clk);
    chk("sw_mmq",    32'(mmq.size()), 0);
    chk("sw_done_h", 32'(m0.done), 1);
  endtask

  initial begin
    m0.start = 1'b0;
    m0.abort = 1'b0;
    m1.start = 1'b0;
    m1.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset0();
    rst = 1'b0;

    run_sweep(1'b0, 1'b0);
    run_sweep(1'b1, 1'b1);
    run_sweep(1'b1, 1'b0);

    fault = 1'b1;
    push_fails(1'b1, 6);
    @(negedge clk) m0.start = 1'b1;
    @(negedge clk) m0.start = 1'b0;
    repeat (29) @(negedge clk);
    chk("ab_cur7", 32'(m0.cur_idx), 7);
    chk("ab_busy", 32'(m0.busy), 1);
    m0.abort = 1'b1;
    m0.start = 1'b1;
    @(negedge clk);
    m0.abort = 1'b0;
    m0.start = 1'b0;
    chk("ab_busy0", 32'(m0.busy), 0);
    chk("ab_done0", 32'(m0.done), 0);
    chk("ab_abcd0", 32'(m0.abcd), 0);
    chk("ab_err",   32'(m0.error_count), 4);
    chk("ab_first", 32'(m0.first_err_idx), 1);
    @(negedge clk);
    chk("ab_ign",   32'(m0.busy), 0);
    chk("ab_mmq",   32'(mmq.size()), 0);

    fault = 1'b0;
    @(negedge clk) m0.start = 1'b1;
    @(negedge clk) m0.start = 1'b0;
    repeat (21) @(negedge clk);
    chk("rs_cur5", 32'(m0.cur_idx), 5);
    rst = 1'b1;
    @(negedge clk);
    chk_reset0();
    rst = 1'b0;
    run_sweep(1'b0, 1'b0);

    @(negedge clk) m1.start = 1'b1;
    @(negedge clk) m1.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("soe_done7", 32'(m1.done), 0);
    @(negedge clk);
    chk("soe_done8", 32'(m1.done), 1);
    chk("soe_busy",  32'(m1.busy), 0);
    chk("soe_err",   32'(m1.error_count), 1);
    chk("soe_first", 32'(m1.first_err_idx), 1);
    chk("soe_cur",   32'(m1.cur_idx), 1);
    chk("soe_pass",  32'(m1.pass), 0);
    chk("soe_mm",    32'(m1.mismatch), 1);
    chk("soe_abcd",  32'(m1.abcd), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/secuenciador_prueba_mnc.md
Name: secuenciador_prueba_mnc

Overview:
Hardware self-test sequencer for the 4-input/2-output gate circuit (inputs A,B,C,D; outputs F1,F2).
- On start, it sweeps the 4-bit input space 0..N_CASES-1.
- For each case it waits a settle interval, samples {F1,F2}, and compares the sample against a packed golden table.
- It reports error count, first failing index and overall pass/fail.
- It sits beside the circuit instance and replaces the simulation-only testbench loop with a synthesizable checker usable on-board.

Parameters:
N_CASES, 16, number of vectors applied (1..16); indices 0..N_CASES-1.
SETTLE, 2, wait cycles between driving abcd and sampling F1/F2 (1..15).
GOLDEN, 32'hEEEE_76EC, expected {F1,F2} per case; GOLDEN[2i+1]=F1, GOLDEN[2i]=F2 for case i.
STOP_ON_ERR, 0, 1 = end the sweep at the first mismatch.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep (sampled in IDLE or DONE)
abort  input  1  cancel a sweep, return to IDLE
f1  input  1  F1 from circuit under test
f2  input  1  F2 from circuit under test
abcd  output  4  stimulus; abcd[3]=A, abcd[2]=B, abcd[1]=C, abcd[0]=D
busy  output  1  sweep in progress (APPLY/SETTLE/CHECK)
done  output  1  sweep finished, results valid; held until start/abort/rst
pass  output  1  valid with done; 1 iff error_count==0
mismatch  output  1  one-cycle pulse in the cycle after a failing CHECK
error_count  output  5  mismatches in current/last sweep
first_err_idx  output  4  index of first mismatch; 0 if none
cur_idx  output  4  case currently applied

Behaviour:
- Single clock domain. Synchronous active-high reset, as decided.
- Reset values: state=IDLE, abcd=0, cur_idx=0, busy=0, done=0, pass=0, mismatch=0, error_count=0, first_err_idx=0.
- rst has priority over everything. Asserting rst mid-sweep returns all outputs to reset values on the next edge.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: when start=1 → APPLY with idx=0. Entering APPLY clears error_count, first_err_idx and done.
- APPLY (1 cycle): abcd<=idx, cur_idx<=idx, settle counter<=SETTLE-1 → SETTLE.
- SETTLE: counter decrements each cycle. When the counter reaches 0 → CHECK. Occupies exactly SETTLE cycles.
- CHECK (1 cycle): compare {f1,f2} against GOLDEN[2idx+1:2idx].
  - On mismatch: error_count+1; mismatch pulses on the next cycle; if error_count was 0, first_err_idx<=idx.
  - Next state: DONE if idx==N_CASES-1, or if mismatch && STOP_ON_ERR. Otherwise idx+1 → APPLY.
- Each case takes SETTLE+2 cycles. DONE is entered N_CASES*(SETTLE+2) edges after the start-sampling edge (64 with defaults).
- DONE: done=1; pass=(error_count==0); abcd holds the last applied vector. start=1 → APPLY with idx=0 (restart).
- busy=1 exactly in APPLY/SETTLE/CHECK.
- Input sampling: f1/f2 are sampled only in CHECK and are ignored elsewhere.
- start while busy is ignored.
- abort in any non-IDLE state → IDLE next edge: busy=0, done=0, abcd=0. Counters hold their values until the next start.
- abort and start in the same cycle: abort wins.
- Width rules:
  - error_count is 5 bits and never exceeds 16, so it cannot wrap.
  - The idx increment is bounded by N_CASES-1, so idx never wraps past 15.

Test Plan:
- Correct circuit, defaults; pulse start → abcd steps 0..15 every 4 cycles; done=1 at edge 64; pass=1; error_count=0; mismatch never pulses.
- F2 stuck-at-0 → 9 mismatch pulses (cases 1,3,5,6,7,9,11,13,15); error_count=9; first_err_idx=1; pass=0.
- STOP_ON_ERR=1, F2 stuck-at-0 → done at edge 8 (after case 1); error_count=1; first_err_idx=1; cur_idx=1.
- abort asserted while cur_idx=7; start re-pulsed in the same cycle → IDLE next edge; busy=0, done=0, abcd=0; start ignored.
- rst pulsed mid-sweep at cur_idx=5 → all outputs at reset values next edge; a new start yields a full clean pass at edge 64.
- start pulsed while busy → no effect. start pulsed in DONE → counters clear; sweep repeats with identical results.
